// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a synchronous FIFO into a framed valid/ready stream via a 2-entry skid buffer
// Ports: clk/rst (sync, active-high); en gates new reads; fifo_rd_en/fifo_data_out/fifo_empty/fifo_underflow
// face the FIFO read side; m_valid/m_data/m_last/m_ready form the output stream; underflow_cnt is a
// saturating count of fifo_underflow cycles, built only when FIFO_READER_UNDERFLOW_CNT_EN is defined.
module fifo_stream_reader #(
  parameter int FIFO_WIDTH = 16,
  parameter int PKT_LEN    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  output logic                  fifo_rd_en,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  output logic                  m_valid,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic [7:0]            underflow_cnt
);
  localparam int BW = PKT_LEN > 1 ? $clog2(PKT_LEN) : 1;
  localparam logic [BW-1:0] LAST = BW'(PKT_LEN - 1);
  logic [FIFO_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic [1:0] occ_q, occ_d;
  logic inflight_q, inflight_d;
  logic [BW-1:0] beat_q, beat_d;
  logic pop;
  logic [2:0] pend;
  assign m_valid = occ_q != 2'd0;
  assign m_data = head_q;
  assign m_last = m_valid && beat_q == LAST;
  assign pop = m_valid && m_ready;
  always_comb begin
    // pend is the occupancy after this edge; a read is issued only if its word still fits next cycle
    pend = {1'b0, occ_q} + {2'b0, inflight_q} - {2'b0, pop};
    fifo_rd_en = !rst && en && !fifo_empty && pend < 3'd2;
    inflight_d = fifo_rd_en;
    occ_d = pend[1:0];
    head_d = (pop && occ_q == 2'd2) ? tail_q :
             (inflight_q && (occ_q == 2'd0 || pop)) ? fifo_data_out : head_q;
    tail_d = (inflight_q && occ_d == 2'd2) ? fifo_data_out : tail_q;
    beat_d = !pop ? beat_q : (beat_q == LAST) ? '0 : beat_q + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q <= '0;
      inflight_q <= 1'b0;
      beat_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q <= occ_d;
      inflight_q <= inflight_d;
      beat_q <= beat_d;
    end
  end
`ifdef FIFO_READER_UNDERFLOW_CNT_EN
  logic [7:0] ucnt_q, ucnt_d;
  assign ucnt_d = (fifo_underflow && ucnt_q != 8'hff) ? ucnt_q + 8'd1 : ucnt_q;
  always_ff @(posedge clk) begin
    if (rst) ucnt_q <= '0;
    else ucnt_q <= ucnt_d;
  end
  assign underflow_cnt = ucnt_q;
`else
  logic unused_underflow;
  assign unused_underflow = fifo_underflow;
  assign underflow_cnt = 8'd0;
`endif
endmodule
